dqn_step_sequencer: RTL and testbench

Sequences one training episode of the DQN datapath. It drives the `step` and `controller` buses that the activation hold registers, forward-prop unit and back-prop unit decode. For each step it runs three phases in order: capture, forward, backprop. It handshakes with the forward and back-prop units and advances `step` from 1 to a programmed episode length. It sits between the top-level trainer FSM (start/done) and the datapath.

---
 rtl/dqn_step_sequencer.sv | 148 ++++++++++++++
 tb/tb_dqn_step_sequencer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/dqn_step_sequencer.sv
// Step/phase sequencer for one DQN training episode: capture, forward, backprop.
// Optional per-phase watchdog enabled by defining SEQ_TIMEOUT_EN.
module dqn_step_sequencer #(
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic [3:0] num_steps,
    input  logic       fwd_done,
    input  logic       bp_done,
    output logic [3:0] step,
    output logic [3:0] controller,
    output logic       fwd_go,
    output logic       bp_go,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        FORWARD,
        BACKPROP,
        FINISH
    } state_t;

    state_t     state;
    logic [3:0] len;

`ifdef SEQ_TIMEOUT_EN
    localparam logic [7:0] TO = 8'(TIMEOUT);
    logic [7:0] cnt;
    logic       err_q;
    assign err = err_q;
`else
    localparam int unused_timeout = TIMEOUT;
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            len        <= 4'd0;
            step       <= 4'd0;
            controller <= 4'd0;
            fwd_go     <= 1'b0;
            bp_go      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
            cnt        <= 8'd0;
            err_q      <= 1'b0;
`endif
        end else begin
            fwd_go <= 1'b0;
            bp_go  <= 1'b0;
            done   <= 1'b0;
            if (abort) begin
                state      <= IDLE;
                step       <= 4'd0;
                controller <= 4'd0;
                busy       <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start) begin
                            len  <= num_steps;
                            busy <= 1'b1;
`ifdef SEQ_TIMEOUT_EN
                            err_q <= 1'b0;
`endif
                            if (num_steps == 4'd0) begin
                                state <= FINISH;
                                done  <= 1'b1;
                            end else begin
                                state      <= CAPTURE;
                                step       <= 4'd1;
                                controller <= 4'd1;
                            end
                        end
                    end
                    CAPTURE: begin
                        state      <= FORWARD;
                        controller <= 4'd2;
                        fwd_go     <= 1'b1;
`ifdef SEQ_TIMEOUT_EN
                        cnt        <= 8'd0;
`endif
                    end
                    FORWARD: begin
                        // fwd_go high marks the first cycle, where done is ignored
                        if (!fwd_go && fwd_done) begin
                            state      <= BACKPROP;
                            controller <= 4'd3;
                            bp_go      <= 1'b1;
`ifdef SEQ_TIMEOUT_EN
                            cnt        <= 8'd0;
                        end else if (cnt == TO) begin
                            state      <= IDLE;
                            step       <= 4'd0;
                            controller <= 4'd0;
                            busy       <= 1'b0;
                            err_q      <= 1'b1;
                        end else begin
                            cnt <= cnt + 8'd1;
`endif
                        end
                    end
                    BACKPROP: begin
                        if (!bp_go && bp_done) begin
                            if (step == len) begin
                                state      <= FINISH;
                                step       <= 4'd0;
                                controller <= 4'd0;
                                done       <= 1'b1;
                            end else begin
                                state      <= CAPTURE;
                                step       <= step + 4'd1;
                                controller <= 4'd1;
                            end
`ifdef SEQ_TIMEOUT_EN
                        end else if (cnt == TO) begin
                            state      <= IDLE;
                            step       <= 4'd0;
                            controller <= 4'd0;
                            busy       <= 1'b0;
                            err_q      <= 1'b1;
                        end else begin
                            cnt <= cnt + 8'd1;
`endif
                        end
                    end
                    FINISH: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dqn_step_sequencer.sv
// Self-checking bench for dqn_step_sequencer against a phase/age reference model.
// Directed scenarios followed by randomized input traffic.
module tb_dqn_step_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] num_steps = 4'd0;
    logic       fwd_done = 1'b0;
    logic       bp_done = 1'b0;
    logic [3:0] step;
    logic [3:0] controller;
    logic       fwd_go;
    logic       bp_go;
    logic       busy;
    logic       done;
    logic       err;

    localparam int TO = 10;
`ifdef SEQ_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    dqn_step_sequencer #(.TIMEOUT(TO)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .abort(abort),
        .num_steps(num_steps),
        .fwd_done(fwd_done),
        .bp_done(bp_done),
        .step(step),
        .controller(controller),
        .fwd_go(fwd_go),
        .bp_go(bp_go),
        .busy(busy),
        .done(done),
        .err(err)
    );

    always #5 clk = ~clk;

    int nchk = 0;
    int nfail = 0;
    int cyc = 0;

    // model: phase 0 idle,1 capture,2 forward,3 backprop,4 finish; age = cycles in phase
    int m_ph, m_step, m_len, m_age;
    bit m_err;

    function automatic void m_reset();
        m_ph = 0; m_step = 0; m_len = 0; m_age = 0; m_err = 1'b0;
    endfunction

    function automatic void m_update(bit st, bit ab, logic [3:0] n, bit fd, bit bd);
        if (ab) begin
            m_ph = 0; m_step = 0;
            return;
        end
        case (m_ph)
            0: if (st) begin
                m_len = int'(n); m_err = 1'b0;
                if (n == 4'd0) m_ph = 4;
                else begin m_ph = 1; m_step = 1; end
            end
            1: begin m_ph = 2; m_age = 0; end
            2: begin
                if (m_age > 0 && fd) begin m_ph = 3; m_age = 0; end
                else if (TO_EN && m_age == TO) begin m_err = 1'b1; m_ph = 0; m_step = 0; end
                else m_age++;
            end
            3: begin
                if (m_age > 0 && bd) begin
                    if (m_step == m_len) begin m_ph = 4; m_step = 0; end
                    else begin m_step++; m_ph = 1; end
                end else if (TO_EN && m_age == TO) begin m_err = 1'b1; m_ph = 0; m_step = 0; end
                else m_age++;
            end
            default: m_ph = 0;
        endcase
    endfunction

    function automatic logic [12:0] m_out();
        logic [3:0] c;
        c = (m_ph >= 1 && m_ph <= 3) ? 4'(m_ph) : 4'd0;
        return {4'(m_step), c, (m_ph == 2 && m_age == 0), (m_ph == 3 && m_age == 0),
                (m_ph != 0), (m_ph == 4), m_err};
    endfunction

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        nchk++;
        assert (o === e) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, o, e, cyc);
        end
    endtask

    task automatic cyc1(input bit st, input bit ab, input logic [3:0] n, input bit fd, input bit bd);
        start = st; abort = ab; num_steps = n; fwd_done = fd; bp_done = bd;
        @(posedge clk);
        #1;
        cyc++;
        if (!rst) m_reset();
        else m_update(st, ab, n, fd, bd);
        chk("outputs", 32'({step, controller, fwd_go, bp_go, busy, done, err}), 32'(m_out()));
        start = 1'b0; abort = 1'b0; fwd_done = 1'b0; bp_done = 1'b0;
    endtask

    // returns done pulses in the earliest honoured cycle of each phase
    task automatic resp1();
        cyc1(1'b0, 1'b0, 4'd0, (m_ph == 2 && m_age >= 1), (m_ph == 3 && m_age >= 1));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, d, nd, ng;
        bit hit;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", 32'({step, controller, fwd_go, bp_go, busy, done, err}), 32'd0);
        rst = 1'b1;
        cyc1(0, 0, 4'd0, 0, 0);

        // three-step episode with minimal handshake latency
        cyc1(1, 0, 4'd3, 0, 0);
        s = cyc; d = -1; nd = 0;
        chk("t1_first", 32'({busy, step, controller}), 32'({1'b1, 4'd1, 4'd1}));
        for (int i = 0; i < 20; i++) begin
            resp1();
            if (done) begin nd++; if (d < 0) d = cyc; end
        end
        chk("t1_latency", 32'(d - s), 32'd15);
        chk("t1_ndone", 32'(nd), 32'd1);
        chk("t1_step_end", 32'(step), 32'd0);

        // zero-length episode
        cyc1(1, 0, 4'd0, 0, 0);
        chk("t2_done", 32'({done, busy, step, fwd_go, bp_go}), 32'({1'b1, 1'b1, 4'd0, 2'b00}));
        cyc1(0, 0, 4'd0, 0, 0);
        chk("t2_idle", 32'({done, busy, fwd_go, bp_go}), 32'd0);

        // spurious done pulses
        cyc1(1, 0, 4'd1, 0, 0);
        cyc1(0, 0, 4'd0, 0, 1);
        cyc1(0, 0, 4'd0, 1, 1);
        chk("t3_fwd_ign", 32'(controller), 32'd2);
        cyc1(0, 0, 4'd0, 0, 1);
        chk("t3_bd_in_fwd", 32'(controller), 32'd2);
        cyc1(0, 0, 4'd0, 1, 0);
        chk("t3_to_bp", 32'({controller, bp_go}), 32'({4'd3, 1'b1}));
        cyc1(0, 0, 4'd0, 0, 1);
        chk("t3_bp_ign", 32'({controller, done}), 32'({4'd3, 1'b0}));
        cyc1(0, 0, 4'd0, 0, 1);
        chk("t3_done", 32'({done, step}), 32'({1'b1, 4'd0}));
        cyc1(0, 0, 4'd0, 0, 0);

        // abort in backprop of step 2 beats bp_done
        cyc1(1, 0, 4'd3, 0, 0);
        hit = 1'b0;
        for (int i = 0; i < 30 && !hit; i++) begin
            if (m_ph == 3 && m_step == 2 && m_age == 1) hit = 1'b1;
            else resp1();
        end
        chk("t4_reach", 32'(hit), 32'd1);
        cyc1(0, 1, 4'd0, 0, 1);
        chk("t4_abort", 32'({step, controller, busy, done}), 32'd0);
        cyc1(1, 0, 4'd1, 0, 0);
        nd = 0;
        for (int i = 0; i < 8; i++) begin
            resp1();
            if (done) nd++;
        end
        chk("t4_restart_done", 32'(nd), 32'd1);

        // asynchronous reset during forward
        cyc1(1, 0, 4'd2, 0, 0);
        cyc1(0, 0, 4'd0, 0, 0);
        #2 rst = 1'b0;
        #1;
        chk("t5_async", 32'({step, controller, fwd_go, bp_go, busy, done, err}), 32'd0);
        m_reset();
        cyc1(0, 0, 4'd0, 0, 0);
        rst = 1'b1;
        cyc1(1, 0, 4'd1, 0, 0);
        chk("t5_restart", 32'({busy, step}), 32'({1'b1, 4'd1}));
        for (int i = 0; i < 6; i++) resp1();

`ifdef SEQ_TIMEOUT_EN
        // watchdog: forward phase never answered
        cyc1(1, 0, 4'd2, 0, 0);
        ng = 0;
        for (int i = 0; i < 40 && !err; i++) begin
            cyc1(0, 0, 4'd0, 0, 0);
            if (done) ng++;
        end
        chk("t6_err", 32'({err, step, busy}), 32'({1'b1, 4'd0, 1'b0}));
        chk("t6_nodone", 32'(ng), 32'd0);
        cyc1(1, 0, 4'd1, 0, 0);
        chk("t6_err_clear", 32'(err), 32'd0);
        for (int i = 0; i < 6; i++) resp1();
`else
        // without the watchdog a phase waits indefinitely
        cyc1(1, 0, 4'd2, 0, 0);
        for (int i = 0; i < 300; i++) cyc1(0, 0, 4'd0, 0, 0);
        chk("t6_wait", 32'({controller, err, busy}), 32'({4'd2, 1'b0, 1'b1}));
        cyc1(0, 1, 4'd0, 0, 0);
`endif

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] n;
            n = ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 4));
            cyc1(($urandom_range(0, 3) == 0), ($urandom_range(0, 60) == 0), n,
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
